serial_paralelo_alineado: RTL

Parametrised serial-to-parallel converter: the successor to the fixed 10-bit deserializer, sitting directly behind the serial line receiver and ahead of the 8b/10b decoder. Shifts in one bit per enabled clock, in LSB-first or MSB-first order. Frames bits into `ANCHO`-bit words and flags each finished word with a one-cycle `valido` strobe. Optionally aligns word boundaries to a comma symbol (K28.5 by default) and re-aligns whenever a comma appears off-boundary.

---
 rtl/serial_paralelo_alineado_if.sv | 33 +++
 rtl/serial_paralelo_alineado.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_paralelo_alineado_if.sv
// Bus between the serial line receiver and the deserializer's consumer.
// Parameter:
//   ANCHO     word width in bits (must match the deserializer's ANCHO)
// Signals:
//   entrada   serial data bit
//   habilitar sample entrada on this edge
//   salidas   last completed word
//   valido    one-cycle strobe, new word in salidas
//   es_coma   word in salidas is the comma or its complement
//   alineado  word boundary established
//   realinear one-cycle strobe, boundary moved by an off-boundary comma
// Modports: master drives the serial side, slave is the deserializer.
interface serial_paralelo_alineado_if #(
  parameter int ANCHO = 10
) ();
  logic             entrada;
  logic             habilitar;
  logic [ANCHO-1:0] salidas;
  logic             valido;
  logic             es_coma;
  logic             alineado;
  logic             realinear;

  modport master (
    output entrada, habilitar,
    input  salidas, valido, es_coma, alineado, realinear
  );

  modport slave (
    input  entrada, habilitar,
    output salidas, valido, es_coma, alineado, realinear
  );
endinterface

// File: rtl/serial_paralelo_alineado.sv
// Parametrised serial-to-parallel converter with optional comma alignment.
// Shifts one bit per enabled clock (LSB- or MSB-first), frames ANCHO-bit words
// and strobes valido for each finished word.
//
// Parameters:
//   ANCHO        word width, 4..32
//   MSB_PRIMERO  0: first bit lands in salidas[0]; 1: in salidas[ANCHO-1]
//   COMA         comma pattern as seen in salidas; ~COMA also matches
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high
//   bus          serial_paralelo_alineado_if.slave (entrada, habilitar in;
//                salidas, valido, es_coma, alineado, realinear out)
//
// Macro SERIAL_PARALELO_ALINEACION_COMA_EN:
//   defined   -> comma comparator and alignment state machine present
//   undefined -> framing free-runs from the first enabled bit after reset,
//                alineado is 1 once out of reset, es_coma/realinear tied 0
//
// state    | meaning
// BUSCANDO | no boundary yet, every enabled bit compared against the comma
// ALINEADO | boundary known, word emitted when contador reaches ANCHO-1;
//          | an off-boundary comma re-anchors the boundary
module serial_paralelo_alineado #(
  parameter int               ANCHO       = 10,
  parameter bit               MSB_PRIMERO = 1'b0,
  parameter logic [ANCHO-1:0] COMA        = 10'h17C
) (
  input logic                   clk,
  input logic                   reset,
  serial_paralelo_alineado_if.slave bus
);

  localparam int             CW     = $clog2(ANCHO);
  localparam logic [CW-1:0]  ULTIMO = CW'(ANCHO - 1);

  logic [ANCHO-1:0] sr;
  logic [ANCHO-1:0] candidato;
  logic [ANCHO-1:0] salidas_q;
  logic [CW-1:0]    contador;
  logic [CW-1:0]    contador_sig;
  logic             emitir;
  logic             pulso_realinear;
  logic             coma_cand;
  logic             valido_q;
  logic             es_coma_q;
  logic             realinear_q;

  // Value sr takes once the current bit is shifted in.
  generate
    if (MSB_PRIMERO) begin : g_msb
      assign candidato = {sr[ANCHO-2:0], bus.entrada};
    end else begin : g_lsb
      assign candidato = {bus.entrada, sr[ANCHO-1:1]};
    end
  endgenerate

`ifdef SERIAL_PARALELO_ALINEACION_COMA_EN
  typedef enum logic {
    BUSCANDO = 1'b0,
    ALINEADO = 1'b1
  } estado_t;

  estado_t estado;
  estado_t estado_sig;

  assign coma_cand = (candidato == COMA) || (candidato == ~COMA);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado <= BUSCANDO;
    end else begin
      estado <= estado_sig;
    end
  end

  always_comb begin
    estado_sig      = estado;
    contador_sig    = contador;
    emitir          = 1'b0;
    pulso_realinear = 1'b0;
    if (bus.habilitar) begin
      case (estado)
        BUSCANDO: begin
          if (coma_cand) begin
            emitir       = 1'b1;
            contador_sig = '0;
            estado_sig   = ALINEADO;
          end
        end
        ALINEADO: begin
          if (contador == ULTIMO) begin
            // A comma exactly on the boundary is an ordinary word.
            emitir       = 1'b1;
            contador_sig = '0;
          end else if (coma_cand) begin
            emitir          = 1'b1;
            pulso_realinear = 1'b1;
            contador_sig    = '0;
          end else begin
            contador_sig = contador + CW'(1);
          end
        end
        default: estado_sig = BUSCANDO;
      endcase
    end
  end

  assign bus.alineado = (estado == ALINEADO);
`else
  logic alineado_q;
  logic unused_coma;

  assign coma_cand   = 1'b0;
  assign unused_coma = ^COMA;

  always_comb begin
    contador_sig    = contador;
    emitir          = 1'b0;
    pulso_realinear = 1'b0;
    if (bus.habilitar) begin
      if (contador == ULTIMO) begin
        emitir       = 1'b1;
        contador_sig = '0;
      end else begin
        contador_sig = contador + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alineado_q <= 1'b0;
    end else begin
      alineado_q <= 1'b1;
    end
  end

  assign bus.alineado = alineado_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr          <= '0;
      contador    <= '0;
      salidas_q   <= '0;
      valido_q    <= 1'b0;
      es_coma_q   <= 1'b0;
      realinear_q <= 1'b0;
    end else begin
      valido_q    <= emitir;
      realinear_q <= pulso_realinear;
      contador    <= contador_sig;
      if (bus.habilitar) begin
        sr <= candidato;
      end
      if (emitir) begin
        salidas_q <= candidato;
        es_coma_q <= coma_cand;
      end
    end
  end

  assign bus.salidas   = salidas_q;
  assign bus.valido    = valido_q;
  assign bus.es_coma   = es_coma_q;
  assign bus.realinear = realinear_q;

endmodule
